// File: rtl/csi2_pkt_handler.sv
// CSI-2 packet handler: decodes the packet header (with ECC check), streams long-packet
// payload as byte-enabled beats, drops CRC bytes and pulses phy_rst_o at end of packet.
module csi2_pkt_handler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        phy_rst_o,
    output logic        hdr_valid_o,
    output logic [7:0]  hdr_di_o,
    output logic [15:0] hdr_wc_o,
    output logic        hdr_ecc_err_o,
    output logic [31:0] tdata_o,
    output logic [3:0]  tkeep_o,
    output logic        tvalid_o,
    output logic        tlast_o
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL, EOP} state_t;

    state_t      state;
    logic [16:0] cnt;

    function automatic logic [5:0] calc_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [16:0] sat_sub4(input logic [16:0] c);
        return (c > 17'd4) ? (c - 17'd4) : 17'd0;
    endfunction

    function automatic logic [3:0] thermo(input logic [2:0] n);
        case (n)
            3'd1:    return 4'h1;
            3'd2:    return 4'h3;
            3'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

    logic        ecc_err;
    logic        is_short;
    logic [16:0] cnt_dec;
    logic [16:0] pay_rem;
    logic        last_beat;

    // cnt still includes the two CRC bytes, so payload left is cnt-2
    assign ecc_err   = calc_ecc(data_i[23:0]) != data_i[29:24];
    assign is_short  = data_i[5:0] <= 6'h0F;
    assign cnt_dec   = sat_sub4(cnt);
    assign pay_rem   = cnt - 17'd2;
    assign last_beat = pay_rem <= 17'd4;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            phy_rst_o     <= 1'b0;
            hdr_valid_o   <= 1'b0;
            hdr_di_o      <= '0;
            hdr_wc_o      <= '0;
            hdr_ecc_err_o <= 1'b0;
            tdata_o       <= '0;
            tkeep_o       <= '0;
            tvalid_o      <= 1'b0;
            tlast_o       <= 1'b0;
        end else begin
            hdr_valid_o <= 1'b0;
            tvalid_o    <= 1'b0;
            tlast_o     <= 1'b0;
            phy_rst_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        hdr_valid_o   <= 1'b1;
                        hdr_di_o      <= data_i[7:0];
                        hdr_wc_o      <= data_i[23:8];
                        hdr_ecc_err_o <= ecc_err;
                        if (ecc_err || is_short) begin
                            state <= EOP;
                        end else begin
                            cnt   <= {1'b0, data_i[23:8]} + 17'd2;
                            state <= (data_i[23:8] == 16'd0) ? TAIL : PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (valid_i) begin
                        tvalid_o <= 1'b1;
                        tdata_o  <= data_i;
                        cnt      <= cnt_dec;
                        if (last_beat) begin
                            tkeep_o <= thermo(pay_rem[2:0]);
                            tlast_o <= 1'b1;
                            state   <= (cnt_dec == 17'd0) ? EOP : TAIL;
                        end else begin
                            tkeep_o <= 4'hF;
                        end
                    end
                end
                TAIL: begin
                    if (valid_i) begin
                        cnt <= cnt_dec;
                        if (cnt_dec == 17'd0) state <= EOP;
                    end
                end
                EOP: begin
                    phy_rst_o <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_pkt_handler.sv
// Scoreboard bench for csi2_pkt_handler: directed packets push expected headers, beats
// and end-of-packet cycles into queues; a negedge monitor pops and compares.
module tb_csi2_pkt_handler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        phy_rst_o;
    logic        hdr_valid_o;
    logic [7:0]  hdr_di_o;
    logic [15:0] hdr_wc_o;
    logic        hdr_ecc_err_o;
    logic [31:0] tdata_o;
    logic [3:0]  tkeep_o;
    logic        tvalid_o;
    logic        tlast_o;

    csi2_pkt_handler dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .phy_rst_o     (phy_rst_o),
        .hdr_valid_o   (hdr_valid_o),
        .hdr_di_o      (hdr_di_o),
        .hdr_wc_o      (hdr_wc_o),
        .hdr_ecc_err_o (hdr_ecc_err_o),
        .tdata_o       (tdata_o),
        .tkeep_o       (tkeep_o),
        .tvalid_o      (tvalid_o),
        .tlast_o       (tlast_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {logic err; logic [15:0] wc; logic [7:0] di;} hdr_t;
    typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last;} beat_t;

    hdr_t  hdr_q[$];
    beat_t beat_q[$];
    int    eop_q[$];

    // Parity-bit coverage masks over the 24 header bits
    localparam logic [23:0] M0 = 24'hF12CB7;
    localparam logic [23:0] M1 = 24'hF2555B;
    localparam logic [23:0] M2 = 24'h749A6D;
    localparam logic [23:0] M3 = 24'hB8E38E;
    localparam logic [23:0] M4 = 24'hDF03F0;
    localparam logic [23:0] M5 = 24'hEFFC00;

    function automatic logic [5:0] ecc_of(input logic [23:0] d);
        return {^(d & M5), ^(d & M4), ^(d & M3), ^(d & M2), ^(d & M1), ^(d & M0)};
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [7:0] di, input logic [15:0] wc,
                                           input logic [1:0] hi, input int flip);
        logic [23:0] h;
        logic [5:0]  e;
        h = {wc, di};
        e = ecc_of(h);
        if (flip >= 0) h[flip] = ~h[flip];
        return {hi, e, h};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (hdr_valid_o) begin
            check("hdr_expected", 64'(hdr_q.size() != 0), 64'd1);
            if (hdr_q.size() != 0) begin
                hdr_t h;
                h = hdr_q.pop_front();
                check("hdr_fields", {hdr_ecc_err_o, hdr_wc_o, hdr_di_o}, h);
            end
        end
        if (tvalid_o) begin
            check("beat_expected", 64'(beat_q.size() != 0), 64'd1);
            if (beat_q.size() != 0) begin
                beat_t b;
                b = beat_q.pop_front();
                check("beat_data_keep_last", {tdata_o, tkeep_o, tlast_o}, b);
            end
        end
        if (phy_rst_o) begin
            check("phy_rst_expected", 64'(eop_q.size() != 0), 64'd1);
            if (eop_q.size() != 0) begin
                int e;
                e = eop_q.pop_front();
                check("phy_rst_cycle", 64'(cyc), 64'(e));
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] d);
        valid_i = v;
        data_i  = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'hDEADBEEF ^ i);
    endtask

    task automatic send_short(input logic [7:0] di, input logic [15:0] wc, input logic [1:0] hi);
        hdr_t h;
        h.err = 1'b0; h.wc = wc; h.di = di;
        hdr_q.push_back(h);
        drive(1'b1, mk_hdr(di, wc, hi, -1));
        eop_q.push_back(cyc + 1);
        idle(2);
    endtask

    // words = body words on the wire (payload + 2 CRC bytes, rounded up to whole words)
    task automatic send_long(input logic [7:0] di, input logic [15:0] wc, input int words,
                             input bit gaps);
        hdr_t  h;
        beat_t b;
        int    nb;
        logic [31:0] w;
        h.err = 1'b0; h.wc = wc; h.di = di;
        hdr_q.push_back(h);
        drive(1'b1, mk_hdr(di, wc, 2'b00, -1));
        nb = (int'(wc) + 3) / 4;
        for (int k = 0; k < words; k++) begin
            w = 32'hA5000000 | (32'(wc) << 8) | 32'(k);
            if (k < nb) begin
                b.data = w;
                b.last = (k == nb - 1);
                b.keep = b.last ? 4'((1 << (int'(wc) - 4 * (nb - 1))) - 1) : 4'hF;
                beat_q.push_back(b);
            end
            if (gaps) idle(k % 3 + 1);
            drive(1'b1, w);
        end
        eop_q.push_back(cyc + 1);
        idle(2);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tdata"}, tdata_o, 64'd0);
        check({name, "_ctrl"}, {phy_rst_o, hdr_valid_o, hdr_ecc_err_o, tkeep_o, tvalid_o,
                                tlast_o, hdr_di_o, hdr_wc_o}, 64'd0);
    endtask

    initial begin
        logic [31:0] bad;
        hdr_t        he;
        beat_t       bb;

        rst_i   = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'h12345678;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset_state");
        rst_i = 1'b1;
        idle(2);

        send_short(8'h00, 16'h0001, 2'b00);
        send_short(8'h0F, 16'hBEEF, 2'b11);
        send_short(8'h41, 16'h0000, 2'b00);

        send_long(8'h2B, 16'd8, 3, 1'b0);
        send_long(8'h2A, 16'd5, 2, 1'b0);
        send_long(8'h10, 16'd3, 2, 1'b0);
        send_long(8'h2C, 16'd0, 1, 1'b0);
        send_long(8'h2B, 16'd4, 2, 1'b0);
        send_long(8'h2B, 16'd6, 2, 1'b0);
        send_long(8'h2B, 16'd7, 3, 1'b0);
        send_long(8'h10, 16'd3, 2, 1'b1);
        send_long(8'h2C, 16'd0, 1, 1'b1);
        send_long(8'h2A, 16'd5, 2, 1'b1);

        // single flipped header bit, then a fresh short header must decode
        bad = mk_hdr(8'h2B, 16'h0010, 2'b00, 12);
        he.err = 1'b1; he.wc = bad[23:8]; he.di = bad[7:0];
        hdr_q.push_back(he);
        drive(1'b1, bad);
        eop_q.push_back(cyc + 1);
        idle(2);
        send_short(8'h01, 16'h0203, 2'b00);

        // reset in the middle of a WC=16 payload
        he.err = 1'b0; he.wc = 16'd16; he.di = 8'h2B;
        hdr_q.push_back(he);
        drive(1'b1, mk_hdr(8'h2B, 16'd16, 2'b00, -1));
        for (int k = 0; k < 2; k++) begin
            bb.data = 32'hC0DE0000 + 32'(k); bb.keep = 4'hF; bb.last = 1'b0;
            beat_q.push_back(bb);
            drive(1'b1, 32'hC0DE0000 + 32'(k));
        end
        @(negedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hC0DE0002;
        #1;
        check_all_zero("mid_packet_reset");
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("held_reset");
        rst_i = 1'b1;
        idle(3);
        send_short(8'h02, 16'h1234, 2'b00);

        for (int i = 0; i < 20 && (hdr_q.size() + beat_q.size() + eop_q.size()) != 0; i++)
            @(posedge clk_i);
        idle(3);
        check("hdr_queue_drained", 64'(hdr_q.size()), 64'd0);
        check("beat_queue_drained", 64'(beat_q.size()), 64'd0);
        check("eop_queue_drained", 64'(eop_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/csi2_pkt_handler.md
CSI2_PKT_HANDLER -- requirements
Module: csi2_pkt_handler

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk_i  input  1  byte clock; the same clock as the PHY 32-bit mapper output.
REQ-003 rst_i  input  1  asynchronous reset, active-low.
REQ-004 data_i  input  32  mapped PHY word; byte0 = [7:0] is the earliest byte on the wire.
REQ-005 valid_i  input  1  data_i qualifier; gaps between valid words are permitted.
REQ-006 phy_rst_o  output  1  end-of-packet pulse to the PHY aligner/mapper eop input.
REQ-007 hdr_valid_o  output  1  one-cycle strobe; the header outputs are valid.
REQ-008 hdr_di_o  output  8  header data identifier.
REQ-009 hdr_wc_o  output  16  header word count, or short-packet data field.
REQ-010 hdr_ecc_err_o  output  1  header ECC syndrome nonzero; qualified by hdr_valid_o.
REQ-011 tdata_o  output  32  long-packet payload.
REQ-012 tkeep_o  output  4  byte enables for tdata_o.
REQ-013 tvalid_o  output  1  payload qualifier; there is no backpressure, so the consumer shall accept every beat.
REQ-014 tlast_o  output  1  marks the last payload beat of a packet.

Function
REQ-015 The header word SHALL be decoded as: DI = byte0, WC = {byte2, byte1}, ECC = byte3.
REQ-016 The block SHALL compute the CSI-2 6-bit ECC over the 24 header bits and compare it with ECC[5:0]; ECC[7:6] SHALL be ignored.
REQ-017 The block SHALL support detection only; no ECC correction is performed.
REQ-018 The FSM SHALL have the states IDLE, PAYLOAD, TAIL and EOP.
REQ-019 In IDLE, the first word with valid_i=1 SHALL be taken as the header.
  - The header outputs SHALL be registered.
  - hdr_valid_o SHALL pulse on the following cycle.
REQ-020 On an ECC error, the block SHALL go to EOP regardless of DI, and SHALL emit no payload.
REQ-021 A header with DI[5:0] <= 0x0F is a short packet, and the block SHALL go to EOP.
REQ-022 Any other DI denotes a long packet.
  - The block SHALL load a 17-bit remaining-bytes counter with WC+2 (payload plus the 2 CRC bytes).
  - If WC=0 it SHALL go to TAIL; otherwise it SHALL go to PAYLOAD.
REQ-023 The counter SHALL decrement by 4 per valid_i word, saturating at 0; it SHALL NOT advance while valid_i=0.
REQ-024 PAYLOAD behaviour per valid word:
  - The block SHALL output tdata_o = data_i and tvalid_o=1, registered with 1 cycle latency.
  - tkeep_o SHALL be 0xF, except on the final payload word, where it SHALL equal the thermometer code of the remaining payload bytes (1->0x1, 2->0x3, 3->0x7, 4->0xF).
REQ-025 tlast_o SHALL be asserted with the beat that carries the last payload byte.
  - If CRC bytes remain after that beat, the block SHALL go to TAIL.
  - Otherwise it SHALL go to EOP.
REQ-026 In TAIL, the block SHALL discard valid words without asserting tvalid_o until the counter reaches 0, then go to EOP.
REQ-027 In EOP, the block SHALL assert phy_rst_o for exactly one cycle, go to IDLE, and ignore data_i during that cycle.
REQ-028 phy_rst_o SHALL be registered.
  - It SHALL be high in the cycle after the FSM enters EOP, that is, 2 cycles after the last word of the packet is accepted.
REQ-029 tvalid_o, tlast_o, hdr_valid_o and phy_rst_o SHALL be single-cycle pulses per event.
  - tdata_o, tkeep_o and the hdr_* data SHALL hold between events.
REQ-030 Outputs SHALL never be X after reset; all registers SHALL be reset.

Reset
REQ-031 While rst_i=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the counter SHALL be 0.
REQ-032 Assertion of rst_i mid-packet SHALL abort the packet immediately with no tlast_o and no phy_rst_o.
REQ-033 After release, the first valid word SHALL be treated as a header.

Verification
REQ-034 Short packet: DI=0x00, WC=0x0001, correct ECC -> hdr_valid_o=1, hdr_di_o=0x00, hdr_wc_o=0x0001, ecc_err=0, tvalid_o never 1, phy_rst_o pulse once.
REQ-035 Long packet, WC=8, 3 body words -> 2 beats with tkeep 0xF/0xF, tlast_o on beat 2, third word discarded, then phy_rst_o pulse.
REQ-036 Long packet, WC=5 -> 2 beats with tkeep 0xF then 0x1; tlast_o on beat 2; no TAIL word; phy_rst_o follows.
REQ-037 Boundary cases:
  - Long packet, WC=3 -> 1 beat with tkeep 0x7 and tlast_o=1; the next word is discarded (TAIL).
  - Long packet, WC=0 -> no beats; 1 word is discarded; phy_rst_o follows.
  - Both cases SHALL be repeated with 1-3 idle cycles inserted between valid words, with identical results.
REQ-038 Long header with a single flipped header bit -> hdr_ecc_err_o=1 together with hdr_valid_o, no tvalid_o, phy_rst_o pulse, and the next valid word is decoded as a new header.
REQ-039 Reset asserted mid-PAYLOAD of a WC=16 packet -> all outputs 0 at once and no phy_rst_o; after release, a short packet is decoded correctly.
